// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA section type, default 640x480 timing and sizing helpers
package vga_pkg;

  typedef enum logic [1:0] {SYNC, BACKPORCH, ACTIVE, FRONTPORCH} section_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - horizontal/vertical counters and section state machines
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = cnt_w(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = cnt_w(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
)(
  input  logic          clk,
  input  logic          nrst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output section_t      h_sec,
  output section_t      v_sec,
  output logic          h_wrap
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  section_t h_sec_nxt;
  section_t v_sec_nxt;
  logic     v_wrap;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      h_sec <= SYNC;
      v_sec <= SYNC;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      h_sec <= h_sec_nxt;
      v_sec <= v_sec_nxt;
      if (h_wrap)
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end
  end

  always_comb begin
    h_sec_nxt = h_sec;
    case (h_sec)
      SYNC:       if (h_cnt == HW'(H_SYNC - 1)) h_sec_nxt = BACKPORCH;
      BACKPORCH:  if (h_cnt == HW'(H_SYNC + H_BP - 1)) h_sec_nxt = ACTIVE;
      ACTIVE:     if (h_cnt == HW'(H_SYNC + H_BP + H_ACTIVE - 1)) h_sec_nxt = FRONTPORCH;
      FRONTPORCH: if (h_wrap) h_sec_nxt = SYNC;
      default:    h_sec_nxt = SYNC;
    endcase
  end

  // Vertical sections only move on the last clock of a line.
  always_comb begin
    v_sec_nxt = v_sec;
    if (h_wrap) begin
      case (v_sec)
        SYNC:       if (v_cnt == VW'(V_SYNC - 1)) v_sec_nxt = BACKPORCH;
        BACKPORCH:  if (v_cnt == VW'(V_SYNC + V_BP - 1)) v_sec_nxt = ACTIVE;
        ACTIVE:     if (v_cnt == VW'(V_SYNC + V_BP + V_ACTIVE - 1)) v_sec_nxt = FRONTPORCH;
        FRONTPORCH: if (v_wrap) v_sec_nxt = SYNC;
        default:    v_sec_nxt = SYNC;
      endcase
    end
  end

  always_comb begin
    h_wrap = (h_cnt == HW'(H_TOTAL - 1));
    v_wrap = (v_cnt == VW'(V_TOTAL - 1));
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - VGA scan-out of a 1-bpp SRAM framebuffer with integer upscaling
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = DEF_H_ACTIVE,
  parameter int          H_FP     = DEF_H_FP,
  parameter int          H_SYNC   = DEF_H_SYNC,
  parameter int          H_BP     = DEF_H_BP,
  parameter int          V_ACTIVE = DEF_V_ACTIVE,
  parameter int          V_FP     = DEF_V_FP,
  parameter int          V_SYNC   = DEF_V_SYNC,
  parameter int          V_BP     = DEF_V_BP,
  parameter int          FB_W     = 128,
  parameter int          FB_H     = 96,
  parameter int          SCALE_X  = 5,
  parameter int          SCALE_Y  = 5,
  parameter logic [31:0] FB_BASE  = 32'h3E80
)(
  input  logic        clk,
  input  logic        nrst,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        pixel,
  output logic        frame_start,
  output logic        underrun
);

  localparam int HW       = cnt_w(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW       = cnt_w(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int HA_START = H_SYNC + H_BP;
  localparam int VA_START = V_SYNC + V_BP;
  localparam int WORDS    = FB_W / 32;
  localparam int XW       = cnt_w(FB_W + 1);
  localparam int SXW      = cnt_w(SCALE_X);
  localparam int YW       = cnt_w(FB_H + 1);
  localparam int SYW      = cnt_w(SCALE_Y);
  localparam int IW       = cnt_w(WORDS + 1);

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  section_t       h_sec;
  section_t       v_sec;
  logic           h_wrap;

  logic [XW-1:0]  fb_x;
  logic [SXW-1:0] rep_x;
  logic [YW-1:0]  fb_y;
  logic [SYW-1:0] rep_y;
  logic [IW-1:0]  idx;
  logic [31:0]    cur, nxt, word;
  logic           cur_valid, nxt_valid, fetch_en, req_live, word_ok;
  logic           line_start, frame_sof, row_vis, in_region, promote, ack_live, issue, ur_set, pix_nxt;
  logic [31:0]    next_addr;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .nrst(nrst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .h_sec(h_sec), .v_sec(v_sec), .h_wrap(h_wrap)
  );

  always_comb begin
    line_start = (h_cnt == '0);
    frame_sof  = line_start && (v_cnt == '0);
    row_vis    = (v_sec == ACTIVE) && (int'(v_cnt) < VA_START + FB_H * SCALE_Y);
    in_region  = row_vis && (h_sec == ACTIVE) && (int'(h_cnt) < HA_START + FB_W * SCALE_X);
    promote    = in_region && (fb_x[4:0] == 5'd0) && (rep_x == '0);
    ack_live   = rd_ack && rd_req && req_live;
    issue      = fetch_en && !line_start && !nxt_valid && !rd_req && (idx < IW'(WORDS));
    ur_set     = fetch_en && promote && !ack_live && !nxt_valid;
    next_addr  = FB_BASE + 32'(fb_y) * 32'(WORDS) + 32'(idx);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fb_x  <= '0;
      rep_x <= '0;
      fb_y  <= '0;
      rep_y <= '0;
    end else begin
      if (line_start) begin
        fb_x  <= '0;
        rep_x <= '0;
      end else if (in_region) begin
        if (rep_x == SXW'(SCALE_X - 1)) begin
          rep_x <= '0;
          fb_x  <= fb_x + 1'b1;
        end else begin
          rep_x <= rep_x + 1'b1;
        end
      end
      if (frame_sof) begin
        fb_y  <= '0;
        rep_y <= '0;
      end else if (h_wrap && row_vis) begin
        if (rep_y == SYW'(SCALE_Y - 1)) begin
          rep_y <= '0;
          fb_y  <= fb_y + 1'b1;
        end else begin
          rep_y <= rep_y + 1'b1;
        end
      end
    end
  end

  // req_live tags the outstanding read; once cleared its data is dropped on arrival.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      req_live  <= 1'b0;
      fetch_en  <= 1'b0;
      idx       <= '0;
      cur       <= '0;
      nxt       <= '0;
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
    end else begin
      if (rd_req && rd_ack) begin
        rd_req <= 1'b0;
      end else if (issue) begin
        rd_req   <= 1'b1;
        rd_addr  <= next_addr;
        req_live <= 1'b1;
      end
      if (line_start) begin
        fetch_en  <= row_vis;
        idx       <= '0;
        cur_valid <= 1'b0;
        nxt_valid <= 1'b0;
        req_live  <= 1'b0;
      end else if (fetch_en) begin
        if (promote) begin
          if (ack_live) begin
            cur       <= rd_data;
            cur_valid <= 1'b1;
            idx       <= idx + 1'b1;
          end else if (nxt_valid) begin
            cur       <= nxt;
            cur_valid <= 1'b1;
            nxt_valid <= 1'b0;
          end else begin
            cur_valid <= 1'b0;
            fetch_en  <= 1'b0;
            req_live  <= 1'b0;
          end
        end else if (ack_live) begin
          nxt       <= rd_data;
          nxt_valid <= 1'b1;
          idx       <= idx + 1'b1;
        end
      end
    end
  end

  // On a promote clock the pixel comes from the word being promoted, not the old cur.
  always_comb begin
    word    = cur;
    word_ok = cur_valid;
    if (promote) begin
      if (ack_live) begin
        word    = rd_data;
        word_ok = 1'b1;
      end else begin
        word    = nxt;
        word_ok = nxt_valid;
      end
    end
    pix_nxt = in_region && fetch_en && word_ok && word[5'd31 - fb_x[4:0]];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      pixel       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      hsync_n     <= (h_sec != SYNC);
      vsync_n     <= (v_sec != SYNC);
      de          <= (h_sec == ACTIVE) && (v_sec == ACTIVE);
      pixel       <= pix_nxt;
      frame_start <= frame_sof;
      if (ur_set)
        underrun <= 1'b1;
      else if (frame_sof)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - directed self-checking bench for vga_fb_scanout
module tb_vga_fb_scanout;

  localparam int H_ACTIVE = 128, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int FB_W = 64, FB_H = 2, SCALE_X = 2, SCALE_Y = 2;
  localparam logic [31:0] FB_BASE = 32'h3E80;
  localparam int HT = 136, FT = 952, HA0 = 6, VA0 = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data = '0;
  logic        hsync_n, vsync_n, de, pixel, frame_start, underrun;

  always #5 clk = ~clk;

  vga_fb_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .FB_W(FB_W), .FB_H(FB_H), .SCALE_X(SCALE_X), .SCALE_Y(SCALE_Y), .FB_BASE(FB_BASE)
  ) dut (
    .clk(clk), .nrst(nrst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .pixel(pixel),
    .frame_start(frame_start), .underrun(underrun)
  );

  logic [31:0] mem [4];
  logic [31:0] addr_log [$];
  logic [31:0] slow_addr;
  int          slow_cyc;
  int          cyc;
  int          n_pass = 0;
  int          n_total = 0;
  logic        hs_s [FT], vs_s [FT], de_s [FT], pix_s [FT], fs_s [FT], ur_s [FT];

  always @(posedge clk or negedge nrst)
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;

  // SRAM: answers at once, except slow_addr which is held back until cycle slow_cyc.
  always @(negedge clk) begin
    rd_ack = 1'b0;
    if (nrst && rd_req && !(rd_addr == slow_addr && cyc < slow_cyc)) begin
      rd_ack  = 1'b1;
      rd_data = mem[2'(rd_addr - FB_BASE)];
      addr_log.push_back(rd_addr);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic capture();
    for (int i = 0; i < FT; i++) begin
      @(negedge clk);
      hs_s[i] = hsync_n; vs_s[i] = vsync_n; de_s[i] = de;
      pix_s[i] = pixel;  fs_s[i] = frame_start; ur_s[i] = underrun;
    end
  endtask

  function automatic logic exp_pix(int v, int x);
    int row, fx;
    logic [31:0] w;
    if (v < VA0 || v >= VA0 + FB_H * SCALE_Y || x >= FB_W * SCALE_X) return 1'b0;
    row = (v - VA0) / SCALE_Y;
    fx  = x / SCALE_X;
    w   = mem[row * (FB_W / 32) + fx / 32];
    return w[31 - fx % 32];
  endfunction

  function automatic logic [127:0] exp_line(int v, int cut);
    logic [127:0] r;
    for (int x = 0; x < 128; x++) r[x] = (x < cut) ? exp_pix(v, x) : 1'b0;
    return r;
  endfunction

  function automatic logic [127:0] obs_line(int v);
    logic [127:0] r;
    for (int x = 0; x < 128; x++) r[x] = pix_s[v * HT + HA0 + x];
    return r;
  endfunction

  initial begin
    int cnt;
    int exp_idx [8];
    logic ok;
    exp_idx = '{0, 1, 0, 1, 2, 3, 2, 3};
    mem[0] = 32'hA000_0001; mem[1] = 32'h4000_0003;
    mem[2] = 32'h1234_5678; mem[3] = 32'hFFFF_0000;
    slow_addr = FB_BASE + 32'd1;
    slow_cyc  = 0;

    repeat (3) @(negedge clk);
    chk("rst_hsync_n", 128'(hsync_n), 128'd1);
    chk("rst_vsync_n", 128'(vsync_n), 128'd1);
    chk("rst_de", 128'(de), 128'd0);
    chk("rst_pixel", 128'(pixel), 128'd0);
    chk("rst_frame_start", 128'(frame_start), 128'd0);
    chk("rst_underrun", 128'(underrun), 128'd0);
    chk("rst_rd_req", 128'(rd_req), 128'd0);
    nrst = 1'b1;

    // Frame 0: zero-latency SRAM, geometry and pixel pattern
    capture();
    chk("f0_first_fs", 128'(fs_s[0]), 128'd1);
    chk("f0_first_hs", 128'(hs_s[0]), 128'd0);
    chk("f0_first_vs", 128'(vs_s[0]), 128'd0);
    cnt = 0; for (int i = 0; i < HT; i++) cnt += int'(!hs_s[i]);
    chk("hsync_low_clocks", 128'(cnt), 128'd3);
    chk("hsync_last_low", 128'(hs_s[2]), 128'd0);
    chk("hsync_first_high", 128'(hs_s[3]), 128'd1);
    cnt = 0; for (int i = 0; i < FT; i++) cnt += int'(!vs_s[i]);
    chk("vsync_low_clocks", 128'(cnt), 128'(HT));
    cnt = 0; for (int i = 0; i < HT; i++) cnt += int'(de_s[3 * HT + i]);
    chk("de_clocks_line3", 128'(cnt), 128'd128);
    cnt = 0; for (int i = 0; i < HT; i++) cnt += int'(de_s[i]);
    chk("de_clocks_line0", 128'(cnt), 128'd0);
    chk("de_before_active", 128'(de_s[3 * HT + 5]), 128'd0);
    chk("de_first_active", 128'(de_s[3 * HT + 6]), 128'd1);
    cnt = 0; for (int i = 0; i < FT; i++) cnt += int'(fs_s[i]);
    chk("frame_start_pulses", 128'(cnt), 128'd1);
    for (int v = 2; v < 6; v++) chk($sformatf("f0_line%0d", v), obs_line(v), exp_line(v, 128));
    chk("f0_pix_x1", 128'(pix_s[2 * HT + HA0 + 1]), 128'd1);
    chk("f0_pix_x2", 128'(pix_s[2 * HT + HA0 + 2]), 128'd0);
    cnt = 0; for (int i = 0; i < FT; i++) cnt += int'(pix_s[i] && !de_s[i]);
    chk("pixel_outside_de", 128'(cnt), 128'd0);
    cnt = 0; for (int i = 0; i < FT; i++) cnt += int'(ur_s[i]);
    chk("f0_underrun", 128'(cnt), 128'd0);
    chk("addr_count", 128'(addr_log.size()), 128'd8);
    ok = (addr_log.size() >= 8);
    for (int i = 0; i < 8 && ok; i++) ok = (addr_log[i] == FB_BASE + 32'(exp_idx[i]));
    chk("addr_sequence", 128'(ok), 128'd1);

    // Frame 1: word 1 of line 2 answered 100 clocks after request
    slow_cyc = FT + VA0 * HT + 108;
    capture();
    chk("ur_line2_x63", 128'(ur_s[2 * HT + 69]), 128'd0);
    chk("ur_line2_x65", 128'(ur_s[2 * HT + 71]), 128'd1);
    chk("f1_line2_cut", obs_line(2), exp_line(2, 64));
    chk("f1_line3", obs_line(3), exp_line(3, 128));
    chk("f1_line4", obs_line(4), exp_line(4, 128));
    chk("ur_sticky_frame_end", 128'(ur_s[FT - 1]), 128'd1);

    // Frame 2: word 1 of line 2 acked exactly on its promote clock
    slow_cyc = 2 * FT + VA0 * HT + 70;
    capture();
    chk("f2_first_fs", 128'(fs_s[0]), 128'd1);
    chk("ur_cleared", 128'(ur_s[0]), 128'd0);
    chk("bypass_pix_x64", 128'(pix_s[2 * HT + HA0 + 64]), 128'd0);
    chk("bypass_pix_x66", 128'(pix_s[2 * HT + HA0 + 66]), 128'd1);
    chk("f2_line2", obs_line(2), exp_line(2, 128));
    chk("f2_line3", obs_line(3), exp_line(3, 128));
    cnt = 0; for (int i = 0; i < FT; i++) cnt += int'(ur_s[i]);
    chk("f2_underrun", 128'(cnt), 128'd0);

    // Frame 3: reset while a read is outstanding
    slow_cyc = 32'h7FFF_FFFF;
    repeat (2 * HT + 40) @(negedge clk);
    chk("req_held", 128'(rd_req), 128'd1);
    nrst = 1'b0;
    #1;
    chk("async_rd_req_drop", 128'(rd_req), 128'd0);
    chk("async_hsync_n", 128'(hsync_n), 128'd1);
    chk("async_vsync_n", 128'(vsync_n), 128'd1);
    chk("async_de", 128'(de), 128'd0);
    chk("async_pixel", 128'(pixel), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
